// File: rtl/gray_seq_monitor.sv
// Gray-code sequence monitor: converts sampled Gray words to binary, checks for +1 progression,
// tracks lock and keeps a saturating count of sequence errors seen while locked.
module gray_seq_monitor #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  locked,
  output logic                  err,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] prev;
  logic [CNT_W-1:0]      acq_cnt;

  logic [DATA_WIDTH-1:0] bin_c;
  logic [DATA_WIDTH-1:0] exp_c;
  logic                  dup_c;
  logic                  step_ok_c;
  logic                  seq_err_c;
  logic                  acq_done_c;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      bin_c[i] = ^(din >> i);
    end
    exp_c      = prev + DATA_WIDTH'(1);
    dup_c      = (state != IDLE) && (bin_c == prev);
    step_ok_c  = (bin_c == exp_c);
    seq_err_c  = din_valid && (state == LOCKED) && !dup_c && !step_ok_c;
    acq_done_c = ((acq_cnt + CNT_W'(1)) == CNT_W'(LOCK_COUNT));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      prev       <= '0;
      acq_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      dout_valid <= din_valid;
      err        <= seq_err_c;

      // Clear takes effect first so a coincident error leaves a count of one.
      if (err_clr) begin
        err_count <= seq_err_c ? ERR_WIDTH'(1) : '0;
      end else if (seq_err_c && (err_count != '1)) begin
        err_count <= err_count + ERR_WIDTH'(1);
      end

      if (din_valid) begin
        dout <= bin_c;
        case (state)
          IDLE: begin
            prev    <= bin_c;
            acq_cnt <= '0;
            state   <= ACQUIRE;
          end
          ACQUIRE: begin
            if (!dup_c) begin
              prev <= bin_c;
              if (step_ok_c) begin
                acq_cnt <= acq_cnt + CNT_W'(1);
                if (acq_done_c) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                acq_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (!dup_c) begin
              prev <= bin_c;
              if (!step_ok_c) begin
                acq_cnt <= '0;
                state   <= ACQUIRE;
                locked  <= 1'b0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Scoreboard bench for gray_seq_monitor: directed scenarios plus a random walk, checked against
// an arithmetic reference model of the sequence rules.
module tb_gray_seq_monitor;

  localparam int DW   = 4;
  localparam int N    = 16;
  localparam int LOCK = 4;
  localparam int EMAX = 255;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          err_clr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          locked;
  logic          err;
  logic [7:0]    err_count;

  gray_seq_monitor #(.DATA_WIDTH(4), .LOCK_COUNT(4), .ERR_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .dout(dout), .dout_valid(dout_valid), .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dout;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nfail = 0;
  bit   in_reset = 1'b0;
  logic [3:0] hold_dout = '0;
  logic       hold_locked = 1'b0;

  // Reference model state
  bit m_have = 0;
  int m_prev = 0;
  int m_run = 0;
  bit m_lk = 0;
  int m_cnt = 0;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & (N - 1);
  endfunction

  // Decode by search: the binary value whose Gray image matches.
  function automatic int bin_of(input int g);
    for (int x = 0; x < N; x++) if (gray_of(x) == g) return x;
    return -1;
  endfunction

  function automatic void model_step(input int g, input bit clr);
    int  b;
    bit  e;
    exp_t x;
    b = bin_of(g);
    e = 0;
    if (!m_have) begin
      m_have = 1; m_prev = b; m_run = 0;
    end else if (b == m_prev) begin
      // stall: nothing changes
    end else if (b == (m_prev + 1) % N) begin
      m_prev = b;
      if (!m_lk) begin
        m_run++;
        if (m_run >= LOCK) m_lk = 1;
      end
    end else begin
      if (m_lk) e = 1;
      m_lk = 0; m_run = 0; m_prev = b;
    end
    if (clr) m_cnt = e ? 1 : 0;
    else if (e && m_cnt < EMAX) m_cnt++;
    x.dout = 4'(b); x.locked = m_lk; x.err = e; x.cnt = 8'(m_cnt);
    exp_q.push_back(x);
  endfunction

  task automatic send(input int b, input bit clr = 1'b0);
    @(negedge clk);
    din = 4'(gray_of(b & (N - 1)));
    din_valid = 1'b1;
    err_clr = clr;
    model_step(gray_of(b & (N - 1)), clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      err_clr = 1'b0;
      din = 4'($urandom_range(0, N - 1));
    end
  endtask

  // Drives v-4..v so the monitor ends up locked at v from any prior state.
  task automatic lock_at(input int v);
    for (int k = LOCK; k >= 0; k--) send((v - k + N) & (N - 1));
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    din_valid = 1'b1;
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (dout !== 4'd0 || dout_valid !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || err_count !== 8'd0) begin
      nfail++;
      $display("FAIL reset_state: got dout=%0d dv=%0b lk=%0b err=%0b cnt=%0d, want all zero",
               dout, dout_valid, locked, err, err_count);
    end
    m_have = 0; m_prev = 0; m_run = 0; m_lk = 0; m_cnt = 0;
    hold_dout = '0; hold_locked = 1'b0;
    exp_q.delete();
    resetn = 1'b1;
    din_valid = 1'b0;
    err_clr = 1'b0;
    in_reset = 1'b0;
  endtask

  // Monitor: pops an expectation on every dout_valid, otherwise checks that outputs hold.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      exp_t e;
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_valid: got dout_valid=1 dout=%0d, want no output", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.dout || locked !== e.locked || err !== e.err || err_count !== e.cnt) begin
          nfail++;
          $display("FAIL sample: got dout=%0d lk=%0b err=%0b cnt=%0d, want dout=%0d lk=%0b err=%0b cnt=%0d",
                   dout, locked, err, err_count, e.dout, e.locked, e.err, e.cnt);
        end
        hold_dout = e.dout;
        hold_locked = e.locked;
      end
    end else if (!in_reset && resetn === 1'b1) begin
      nvec++;
      if (dout !== hold_dout || locked !== hold_locked || err !== 1'b0 || dout_valid !== 1'b0) begin
        nfail++;
        $display("FAIL hold: got dout=%0d lk=%0b err=%0b dv=%0b, want dout=%0d lk=%0b err=0 dv=0",
                 dout, locked, err, dout_valid, hold_dout, hold_locked);
      end
    end
  end

  initial begin
    int cur;
    int r;
    resetn = 1'b1;
    din = '0;
    din_valid = 1'b0;
    err_clr = 1'b0;
    do_reset();

    // 1: acquisition from reset
    send(0); send(1); send(2); send(3); send(4);
    idle(2);
    // 2: wrap through 15 -> 0
    lock_at(14); send(15); send(0);
    idle(1);
    // 3: error while locked, then relock
    lock_at(4); send(7); send(8); send(9); send(10); send(11);
    idle(1);
    // 4: stalls and gap while locked
    lock_at(2); send(2); send(2); send(2); idle(2); send(3); send(4);
    idle(1);
    // 5: saturate the error counter, then clear coincident with an error
    for (int k = 0; k < EMAX + 3; k++) begin
      r = $urandom_range(0, N - 1);
      lock_at(r);
      send(r + 2);
    end
    lock_at(5); send(9, 1'b1);
    idle(1);
    // 6: reset while locked with err_count = 3
    lock_at(1); send(1, 1'b1);
    for (int k = 0; k < 3; k++) begin lock_at(k + 6); send(k + 9); end
    lock_at(12);
    idle(1);
    do_reset();
    send(7); send(8);
    idle(1);

    // Random walk: mostly +1, with stalls, jumps, gaps and occasional clears
    cur = 8;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15) idle(1);
      else begin
        if (r < 75) cur = (cur + 1) % N;
        else if (r < 87) cur = cur;
        else cur = $urandom_range(0, N - 1);
        send(cur, $urandom_range(0, 99) < 4);
      end
    end
    idle(1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL drain: got %0d outstanding expectations, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
